// File: rtl/video_fetch_pkg.sv
// video_fetch_pkg: shared types and constants for the video line fetch controller.
// Holds the FSM state encoding, per-mode word counts, credit depth and counter widths.
package video_fetch_pkg;

   localparam int CNT_W    = 7;   // enough for the widest line (80 words)
   localparam int CREDIT_W = 4;   // holds 0..8

   localparam logic [CREDIT_W-1:0] CREDIT_MAX = 4'd8;

   localparam logic [CNT_W-1:0] WPL_TEXT  = 7'd80;
   localparam logic [CNT_W-1:0] WPL_AG    = 7'd80;
   localparam logic [CNT_W-1:0] WPL_P16C  = 7'd64;
   localparam logic [CNT_W-1:0] WPL_HMCLR = 7'd32;
   localparam logic [CNT_W-1:0] WPL_ZX    = 7'd32;
   localparam logic [CNT_W-1:0] WPL_NONE  = 7'd0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_FETCH = 2'd2,
      ST_DRAIN = 2'd3
   } fetch_state_t;

   // Words fetched per visible line for the decoded mode set.
   // When several mode bits are set, text wins over ag, then p_16c, p_hmclr, zx.
   function automatic logic [CNT_W-1:0] mode_words(input logic zx,
                                                   input logic p_16c,
                                                   input logic p_hmclr,
                                                   input logic ag,
                                                   input logic a_text);
      logic [CNT_W-1:0] w;
      if (a_text)       w = WPL_TEXT;
      else if (ag)      w = WPL_AG;
      else if (p_16c)   w = WPL_P16C;
      else if (p_hmclr) w = WPL_HMCLR;
      else if (zx)      w = WPL_ZX;
      else              w = WPL_NONE;
      return w;
   endfunction

endpackage

// File: rtl/video_fetch_credit.sv
// video_fetch_credit: counts free word slots in the downstream pixel buffer.
// A granted request takes a slot, a buffer pop gives one back; the count
// saturates at CREDIT_MAX and never underflows.
module video_fetch_credit
   import video_fetch_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                init_i,
   input  logic                take_i,
   input  logic                give_i,
   output logic [CREDIT_W-1:0] credits_o,
   output logic                nonzero_o
);

   logic [CREDIT_W-1:0] credits_q;

   // Credit count: refilled on reset/init, a simultaneous take and give cancel out.
   always_ff @(posedge clk_i) begin
      if (rst_i || init_i) begin
         credits_q <= CREDIT_MAX;
      end else if (take_i && !give_i) begin
         if (credits_q != '0) credits_q <= credits_q - 4'd1;
      end else if (give_i && !take_i) begin
         if (credits_q != CREDIT_MAX) credits_q <= credits_q + 4'd1;
      end
   end

   assign credits_o = credits_q;
   assign nonzero_o = (credits_q != '0);

endmodule

// File: rtl/video_fetch_ctrl.sv
// video_fetch_ctrl: per-line DRAM fetch sequencer for the video pipeline.
// Latches the line length from the video mode, issues word requests to the
// arbiter under buffer-credit flow control and waits for all words to land.
// Build option: define VIDEO_FETCH_EARLY_EN to start fetching straight from
// line_start (no wait for fetch_start).
module video_fetch_ctrl
   import video_fetch_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                line_start,
   input  logic                vpix,
   input  logic                int_start,
   input  logic                fetch_start,
   input  logic                mode_zx,
   input  logic                mode_p_16c,
   input  logic                mode_p_hmclr,
   input  logic                mode_ag,
   input  logic                mode_a_text,
   output logic                video_go,
   input  logic                video_next,
   input  logic                video_strobe,
   input  logic                buf_pop,
   output logic                fetch_active,
   output logic                line_done,
   output logic                line_err,
   output fetch_state_t        dbg_state_o,
   output logic [CREDIT_W-1:0] dbg_credits_o
);

   // State a new line (or an aborted one) enters.
`ifdef VIDEO_FETCH_EARLY_EN
   localparam fetch_state_t LINE_TGT = ST_FETCH;
`else
   localparam fetch_state_t LINE_TGT = ST_ARM;
`endif

   fetch_state_t       state_q;
   logic [CNT_W-1:0]   req_cnt_q;
   logic [CNT_W-1:0]   rcv_cnt_q;
   logic [CNT_W-1:0]   wpl_q;
   logic               line_done_q;
   logic               line_err_q;

   logic [CNT_W-1:0]   wpl_mode;
   logic               new_line;
   logic               grant;
   logic               credit_nz;
   logic [CREDIT_W-1:0] credits;

   assign wpl_mode = mode_words(mode_zx, mode_p_16c, mode_p_hmclr, mode_ag, mode_a_text);
   assign new_line = line_start & vpix;

   // Request handshake: video_go is the valid, video_next the ready. A word
   // request is transferred only in a cycle where both are high; video_next
   // is ignored while video_go is low. video_go depends on registers only.
   assign video_go = (state_q == ST_FETCH) && (req_cnt_q < wpl_q) && credit_nz;
   assign grant    = video_go & video_next;

   video_fetch_credit u_credit (
      .clk_i     (clk),
      .rst_i     (rst),
      .init_i    (int_start),
      .take_i    (grant),
      .give_i    (buf_pop),
      .credits_o (credits),
      .nonzero_o (credit_nz)
   );

   // Line fetch FSM: frame start beats everything, a new line while busy
   // aborts the current one, otherwise IDLE -> ARM -> FETCH -> DRAIN -> IDLE.
   always_ff @(posedge clk) begin
      if (rst || int_start) begin
         state_q     <= ST_IDLE;
         req_cnt_q   <= '0;
         rcv_cnt_q   <= '0;
         wpl_q       <= '0;
         line_done_q <= 1'b0;
         line_err_q  <= 1'b0;
      end else begin
         line_done_q <= 1'b0;
         if (new_line && state_q != ST_IDLE) begin
            // Overrun: the previous line never finished. Restart with the
            // new mode; a zero-length mode has nothing to fetch, so go idle.
            line_err_q <= 1'b1;
            req_cnt_q  <= '0;
            rcv_cnt_q  <= '0;
            wpl_q      <= wpl_mode;
            state_q    <= (wpl_mode == '0) ? ST_IDLE : LINE_TGT;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (new_line && wpl_mode != '0) begin
                     wpl_q     <= wpl_mode;
                     req_cnt_q <= '0;
                     rcv_cnt_q <= '0;
                     state_q   <= LINE_TGT;
                  end
               end
               ST_ARM: begin
                  if (fetch_start) begin
                     req_cnt_q <= '0;
                     rcv_cnt_q <= '0;
                     state_q   <= ST_FETCH;
                  end
               end
               ST_FETCH: begin
                  if (grant)        req_cnt_q <= req_cnt_q + 7'd1;
                  if (video_strobe) rcv_cnt_q <= rcv_cnt_q + 7'd1;
                  if (req_cnt_q == wpl_q) state_q <= ST_DRAIN;
               end
               ST_DRAIN: begin
                  if (rcv_cnt_q >= wpl_q) begin
                     state_q     <= ST_IDLE;
                     line_done_q <= 1'b1;
                  end else if (video_strobe) begin
                     rcv_cnt_q <= rcv_cnt_q + 7'd1;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign fetch_active  = (state_q != ST_IDLE);
   assign line_done     = line_done_q;
   assign line_err      = line_err_q;
   assign dbg_state_o   = state_q;
   assign dbg_credits_o = credits;

endmodule
